// File: rtl/audio_ctrl_pkg.sv
// Shared types and helpers for the record/playback sequencer.
package audio_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_FAST   = 2'd1,
    MODE_SLOW0  = 2'd2,
    MODE_SLOW1  = 2'd3
  } mode_t;

  // Slots are equal power-of-two regions, so the base is the index shifted up by the offset width.
  function automatic logic [31:0] slot_base(input logic [31:0] slot, input int unsigned off_w);
    return slot << off_w;
  endfunction

endpackage

// File: rtl/slot_len_table.sv
// Per-slot recorded-length registers: one synchronous write port, one asynchronous read port.
module slot_len_table #(
  parameter int N_SLOTS = 4,
  parameter int SLOT_W  = 2,
  parameter int LEN_W   = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [SLOT_W-1:0] i_wr_slot,
  input  logic [LEN_W-1:0]  i_wr_len,
  input  logic [SLOT_W-1:0] i_rd_slot,
  output logic [LEN_W-1:0]  o_rd_len
);

  logic [LEN_W-1:0] len_q [N_SLOTS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
    end else if (i_we) begin
      len_q[i_wr_slot] <= i_wr_len;
    end
  end

  assign o_rd_len = len_q[i_rd_slot];

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: slot-based recording with auto-stop, playback with latched speed/mode.
module rec_play_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int N_SLOTS = 4,
  parameter int SLOT_W  = $clog2(N_SLOTS),
  parameter int SPEED_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_i2c_fin,
  input  logic                     i_key_rec,
  input  logic                     i_key_play,
  input  logic                     i_key_stop,
  input  logic [SLOT_W-1:0]        i_slot,
  input  logic [SPEED_W-1:0]       i_speed,
  input  logic [1:0]               i_mode,
  input  logic [ADDR_W-1:0]        i_rec_addr,
  input  logic [ADDR_W-1:0]        i_play_addr,
  output logic                     o_i2c_start,
  output logic                     o_rec_start,
  output logic                     o_rec_pause,
  output logic                     o_rec_stop,
  output logic                     o_dsp_start,
  output logic                     o_dsp_pause,
  output logic                     o_dsp_stop,
  output logic                     o_play_en,
  output logic [SPEED_W-1:0]       o_speed,
  output logic                     o_fast,
  output logic                     o_slow_0,
  output logic                     o_slow_1,
  output logic [ADDR_W-1:0]        o_slot_base,
  output logic [ADDR_W-SLOT_W:0]   o_slot_len,
  output logic                     o_full,
  output logic                     o_err,
  output logic [2:0]               o_state
);

  localparam int OFF_W = ADDR_W - SLOT_W;
  localparam int LEN_W = OFF_W + 1;
  localparam logic [LEN_W-1:0]  SLOT_SIZE = {1'b1, {OFF_W{1'b0}}};
  localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'({OFF_W{1'b1}});

  state_t             state;
  logic [SLOT_W-1:0]  active_slot;
  logic [ADDR_W-1:0]  base;
  logic [LEN_W-1:0]   cur_len;
  logic [OFF_W-1:0]   rec_off;
  logic [LEN_W-1:0]   play_off;
  logic               slot_full;
  logic               play_end;
  logic               len_we;
  logic [LEN_W-1:0]   len_wdata;

  assign base      = ADDR_W'(slot_base(32'(active_slot), OFF_W));
  assign rec_off   = OFF_W'(i_rec_addr - base);
  assign play_off  = LEN_W'(i_play_addr - base);
  assign slot_full = (i_rec_addr == base + SLOT_LAST);
  // Offset is one bit wider than the slot so a full slot (len = SLOT_SIZE) still compares correctly.
  assign play_end  = (play_off >= cur_len);

  always_comb begin
    len_we    = 1'b0;
    len_wdata = {1'b0, rec_off} + LEN_W'(1);
    if (!i_rst && (state == ST_RECD || state == ST_RECD_PAUSE)) begin
      if (i_key_stop) begin
        len_we = 1'b1;
      end else if (state == ST_RECD && slot_full) begin
        len_we    = 1'b1;
        len_wdata = SLOT_SIZE;
      end
    end
  end

  slot_len_table #(
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W),
    .LEN_W   (LEN_W)
  ) u_len_table (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (len_we),
    .i_wr_slot (active_slot),
    .i_wr_len  (len_wdata),
    .i_rd_slot (active_slot),
    .o_rd_len  (cur_len)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_INIT;
      active_slot <= '0;
      o_i2c_start <= 1'b0;
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;
      o_play_en   <= 1'b0;
      o_speed     <= '0;
      o_fast      <= 1'b0;
      o_slow_0    <= 1'b0;
      o_slow_1    <= 1'b0;
      o_full      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;
      o_full      <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        ST_INIT: begin
          if (i_i2c_fin) begin
            state       <= ST_IDLE;
            o_i2c_start <= 1'b0;
          end else begin
            o_i2c_start <= 1'b1;
          end
        end
        ST_IDLE: begin
          active_slot <= i_slot;
          if (i_key_stop) begin
            state <= ST_IDLE;
          end else if (i_key_rec) begin
            o_rec_start <= 1'b1;
            state       <= ST_RECD;
          end else if (i_key_play) begin
            if (cur_len == '0) begin
              o_err <= 1'b1;
            end else begin
              o_speed     <= i_speed;
              o_fast      <= (mode_t'(i_mode) == MODE_FAST);
              o_slow_0    <= (mode_t'(i_mode) == MODE_SLOW0);
              o_slow_1    <= (mode_t'(i_mode) == MODE_SLOW1);
              o_dsp_start <= 1'b1;
              o_play_en   <= 1'b1;
              state       <= ST_PLAY;
            end
          end
        end
        ST_RECD: begin
          if (i_key_stop) begin
            o_rec_stop <= 1'b1;
            state      <= ST_IDLE;
          end else if (slot_full) begin
            o_rec_stop <= 1'b1;
            o_full     <= 1'b1;
            state      <= ST_IDLE;
          end else if (i_key_rec) begin
            o_rec_pause <= 1'b1;
            state       <= ST_RECD_PAUSE;
          end
        end
        ST_RECD_PAUSE: begin
          if (i_key_stop) begin
            o_rec_stop <= 1'b1;
            state      <= ST_IDLE;
          end else if (i_key_rec) begin
            o_rec_start <= 1'b1;
            state       <= ST_RECD;
          end
        end
        ST_PLAY: begin
          if (i_key_stop || play_end) begin
            o_dsp_stop <= 1'b1;
            o_play_en  <= 1'b0;
            state      <= ST_IDLE;
          end else if (i_key_play) begin
            o_dsp_pause <= 1'b1;
            o_play_en   <= 1'b0;
            state       <= ST_PLAY_PAUSE;
          end
        end
        ST_PLAY_PAUSE: begin
          if (i_key_stop) begin
            o_dsp_stop <= 1'b1;
            o_play_en  <= 1'b0;
            state      <= ST_IDLE;
          end else if (i_key_play) begin
            o_dsp_start <= 1'b1;
            o_play_en   <= 1'b1;
            state       <= ST_PLAY;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign o_slot_base = base;
  assign o_slot_len  = cur_len;
  assign o_state     = state;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_rec_play_ctrl;

  localparam int ADDR_W  = 20;
  localparam int N_SLOTS = 4;
  localparam int SLOT_W  = 2;
  localparam int SPEED_W = 4;
  localparam int SIZE    = 1 << (ADDR_W - SLOT_W);

  logic clk = 1'b0;
  logic rst, i2c_fin, key_rec, key_play, key_stop;
  logic [SLOT_W-1:0]  slot;
  logic [SPEED_W-1:0] speed;
  logic [1:0]         mode;
  logic [ADDR_W-1:0]  rec_addr, play_addr;
  logic o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop;
  logic o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en;
  logic [SPEED_W-1:0] o_speed;
  logic o_fast, o_slow_0, o_slow_1, o_full, o_err;
  logic [ADDR_W-1:0]  o_slot_base;
  logic [ADDR_W-SLOT_W:0] o_slot_len;
  logic [2:0] o_state;

  rec_play_ctrl #(.ADDR_W(ADDR_W), .N_SLOTS(N_SLOTS), .SPEED_W(SPEED_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_i2c_fin(i2c_fin),
    .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
    .i_slot(slot), .i_speed(speed), .i_mode(mode),
    .i_rec_addr(rec_addr), .i_play_addr(play_addr),
    .o_i2c_start(o_i2c_start), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
    .o_rec_stop(o_rec_stop), .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause),
    .o_dsp_stop(o_dsp_stop), .o_play_en(o_play_en), .o_speed(o_speed),
    .o_fast(o_fast), .o_slow_0(o_slow_0), .o_slow_1(o_slow_1),
    .o_slot_base(o_slot_base), .o_slot_len(o_slot_len),
    .o_full(o_full), .o_err(o_err), .o_state(o_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cnt_rec_start = 0, cnt_rec_stop = 0, cnt_full = 0, cnt_dsp_start = 0, cnt_any = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: abstract state number, slot lengths as integers.
  bit m_valid = 0;
  int m_st, m_slot, m_speed, m_mode;
  int m_len [N_SLOTS];
  bit e_i2c, e_rs, e_rp, e_rstop, e_ds, e_dp, e_dstop, e_en, e_full, e_err;

  always @(posedge clk) begin
    int base;
    {e_rs, e_rp, e_rstop, e_ds, e_dp, e_dstop, e_full, e_err} = '0;
    if (rst) begin
      m_valid = 1; m_st = 0; m_slot = 0; m_speed = 0; m_mode = 0;
      foreach (m_len[i]) m_len[i] = 0;
      e_i2c = 0; e_en = 0;
    end else if (m_valid) begin
      base = m_slot * SIZE;
      case (m_st)
        0: if (i2c_fin) begin m_st = 1; e_i2c = 0; end else e_i2c = 1;
        1: begin
          if (key_stop) ;
          else if (key_rec) begin e_rs = 1; m_st = 2; end
          else if (key_play) begin
            if (m_len[m_slot] == 0) e_err = 1;
            else begin m_speed = speed; m_mode = mode; e_ds = 1; e_en = 1; m_st = 4; end
          end
          m_slot = slot;
        end
        2: begin
          if (key_stop) begin e_rstop = 1; m_len[m_slot] = int'(rec_addr) - base + 1; m_st = 1; end
          else if (int'(rec_addr) == base + SIZE - 1) begin
            e_rstop = 1; e_full = 1; m_len[m_slot] = SIZE; m_st = 1;
          end else if (key_rec) begin e_rp = 1; m_st = 3; end
        end
        3: begin
          if (key_stop) begin e_rstop = 1; m_len[m_slot] = int'(rec_addr) - base + 1; m_st = 1; end
          else if (key_rec) begin e_rs = 1; m_st = 2; end
        end
        4: begin
          if (key_stop || (int'(play_addr) - base >= m_len[m_slot])) begin e_dstop = 1; e_en = 0; m_st = 1; end
          else if (key_play) begin e_dp = 1; e_en = 0; m_st = 5; end
        end
        5: begin
          if (key_stop) begin e_dstop = 1; e_en = 0; m_st = 1; end
          else if (key_play) begin e_ds = 1; e_en = 1; m_st = 4; end
        end
        default: ;
      endcase
    end
  end

  // Scoreboard: one whole-output comparison per cycle, plus pulse tallies.
  always @(negedge clk) begin
    logic [58:0] act, exp;
    if (m_valid) begin
      act = {o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause,
             o_dsp_stop, o_play_en, o_fast, o_slow_0, o_slow_1, o_full, o_err,
             o_state, o_speed, o_slot_base, o_slot_len};
      exp = {e_i2c, e_rs, e_rp, e_rstop, e_ds, e_dp, e_dstop, e_en,
             m_mode == 1, m_mode == 2, m_mode == 3, e_full, e_err,
             3'(m_st), 4'(m_speed), 20'(m_slot * SIZE), 19'(m_len[m_slot])};
      check("cycle_model", 64'(act), 64'(exp));
      cnt_rec_start += int'(o_rec_start);
      cnt_rec_stop  += int'(o_rec_stop);
      cnt_full      += int'(o_full);
      cnt_dsp_start += int'(o_dsp_start);
      cnt_any += int'(o_rec_start) + int'(o_rec_pause) + int'(o_rec_stop) + int'(o_dsp_start)
               + int'(o_dsp_pause) + int'(o_dsp_stop) + int'(o_full) + int'(o_err);
    end
  end

  // Driver tasks (called on a falling edge, return on a falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit r, input bit p, input bit s);
    key_rec = r; key_play = p; key_stop = s;
    @(negedge clk);
    key_rec = 0; key_play = 0; key_stop = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs0, rt0, ds0;
    rst = 1; i2c_fin = 0; key_rec = 0; key_play = 0; key_stop = 0;
    slot = 0; speed = 0; mode = 0; rec_addr = 0; play_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", o_state, 3'd0);
    check("reset_i2c", o_i2c_start, 1'b0);
    rst = 0;

    // 1: INIT holds the codec request until i2c_fin
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("init_i2c_high", {o_i2c_start, o_state}, {1'b1, 3'd0});
    end
    i2c_fin = 1;
    tick(1);
    check("init_to_idle", {o_i2c_start, o_state}, {1'b0, 3'd1});
    check("init_no_pulses", cnt_any, 0);

    // 2: record slot 2, stop at 0x800FF
    slot = 2; tick(2);
    rs0 = cnt_rec_start; rt0 = cnt_rec_stop;
    rec_addr = 20'h80000;
    press(1, 0, 0);
    check("rec_start", {o_rec_start, o_state}, {1'b1, 3'd2});
    for (int a = 1; a < 'hFF; a++) begin
      rec_addr = 20'h80000 + 20'(a);
      tick(1);
    end
    rec_addr = 20'h800FF;
    press(0, 0, 1);
    check("rec_stop", {o_rec_stop, o_full, o_state}, {1'b1, 1'b0, 3'd1});
    check("len2", o_slot_len, 19'h100);
    tick(1);
    check("rec_pulse_counts", {16'(cnt_rec_start - rs0), 16'(cnt_rec_stop - rt0)}, {16'd1, 16'd1});

    // 3: record slot 1 until it fills
    slot = 1; tick(2);
    check("slot1_base", o_slot_base, 20'h40000);
    rec_addr = 20'h40000;
    press(1, 0, 0);
    rec_addr = 20'h40010; tick(1);
    rec_addr = 20'h7FFFC; tick(1);
    rec_addr = 20'h7FFFD; tick(1);
    rec_addr = 20'h7FFFE; tick(1);
    check("not_full_yet", {o_full, o_state}, {1'b0, 3'd2});
    rec_addr = 20'h7FFFF; tick(1);
    check("auto_full", {o_full, o_rec_stop, o_state}, {1'b1, 1'b1, 3'd1});
    check("len1_full", o_slot_len, 19'h40000);
    slot = 2; tick(2);
    check("len2_kept", o_slot_len, 19'h100);

    // 4: play slot 2, slow linear, speed 2, auto-stop at the recorded end
    ds0 = cnt_dsp_start;
    mode = 2'd3; speed = 4'd2; play_addr = 20'h80000;
    press(0, 1, 0);
    check("play_start", {o_dsp_start, o_play_en, o_state}, {1'b1, 1'b1, 3'd4});
    check("play_latch", {o_fast, o_slow_0, o_slow_1, o_speed}, {1'b0, 1'b0, 1'b1, 4'd2});
    mode = 2'd1; speed = 4'd7;
    for (int a = 1; a < 'h100; a++) begin
      play_addr = 20'h80000 + 20'(a);
      tick(1);
    end
    check("play_before_end", {o_play_en, o_state}, {1'b1, 3'd4});
    play_addr = 20'h80100; tick(1);
    check("play_auto_stop", {o_dsp_stop, o_play_en, o_state}, {1'b1, 1'b0, 3'd1});
    check("latch_held", {o_slow_1, o_speed}, {1'b1, 4'd2});

    // 5: play on empty slot 0
    slot = 0; tick(2);
    press(0, 1, 0);
    check("empty_err", {o_err, o_dsp_start, o_state}, {1'b1, 1'b0, 3'd1});
    tick(1);
    check("dsp_start_count", cnt_dsp_start - ds0, 1);

    // 6: pause, stop beats play, then reset mid-play
    slot = 2; tick(2);
    mode = 2'd1; speed = 4'd5; play_addr = 20'h80000;
    press(0, 1, 0);
    check("play2_fast", {o_fast, o_speed, o_state}, {1'b1, 4'd5, 3'd4});
    press(0, 1, 0);
    check("play_pause", {o_dsp_pause, o_play_en, o_state}, {1'b1, 1'b0, 3'd5});
    press(0, 1, 1);
    check("stop_wins", {o_dsp_stop, o_dsp_start, o_state}, {1'b1, 1'b0, 3'd1});
    press(0, 1, 0);
    check("play3", o_state, 3'd4);
    rst = 1; tick(1); rst = 0;
    check("reset_mid_play", {o_play_en, o_state, o_speed}, {1'b0, 3'd0, 4'd0});
    tick(3);
    check("len_lost", {o_state, o_slot_len}, {3'd1, 19'h0});

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
